// File: rtl/seq_decoder_n.sv
// -----------------------------------------------------------------------------
// seq_decoder_n
// Parametrised serial pattern decoder. After reset, an N-bit pattern and a
// per-bit compare mask are shifted in serially (MSB first) while enable is
// high. The qualified sig stream is then shifted into an N-bit window. Each
// time the window matches the pattern on all masked bits, a one-cycle pulse
// appears on out. The comparison is made on the window value that includes
// the incoming bit.
//
// Optional feature macro: SEQ_DEC_MATCH_CNT_EN
//   When defined, match_count is a saturating count of out pulses.
//   When undefined, match_count is tied to 0 and no counter flops exist.
//
// Parameters
//   N      pattern length in bits (2..32)
//   CNT_W  width of match_count
// Ports
//   clk          in   clock; all state changes on posedge
//   clr          in   synchronous active-high reset
//   enable       in   programming strobe (honoured in LOAD only)
//   prgm         in   serial pattern bit, pattern[N-1] first
//   prgm_mask    in   serial mask bit (1 = compare, 0 = don't care)
//   sig          in   serial data bit under test
//   sig_valid    in   qualifier for sig
//   mode_nonovl  in   1 = non-overlapping matches, 0 = overlapping
//   out          out  registered one-cycle match pulse
//   armed        out  high while in ARMED
//   match_count  out  saturating match counter
// -----------------------------------------------------------------------------
module seq_decoder_n #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic             prgm,
    input  logic             prgm_mask,
    input  logic             sig,
    input  logic             sig_valid,
    input  logic             mode_nonovl,
    output logic             out,
    output logic             armed,
    output logic [CNT_W-1:0] match_count
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_pattern;
    logic [N-1:0]    r_mask;
    logic [N-1:0]    r_window;
    logic [CW-1:0]   r_load_cnt;
    logic [CW-1:0]   r_fill_cnt;
    logic            r_out;
    logic            r_armed;

    logic [N-1:0]    w_window_next;
    logic            w_match;
    logic            w_load_last;
    logic            w_fill_last;
    logic            w_hit;

    assign w_window_next = {r_window[N-2:0], sig};
    assign w_match       = ((w_window_next ^ r_pattern) & r_mask) == '0;
    assign w_load_last   = (r_load_cnt == CW'(N - 1));
    assign w_fill_last   = (r_fill_cnt == CW'(N - 1));

    // A hit needs a full window: either already ARMED, or this valid bit is
    // the one that completes the window in FILL.
    assign w_hit = sig_valid && w_match &&
                   ((r_state == ARMED) || ((r_state == FILL) && w_fill_last));

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= LOAD;
            r_pattern  <= '0;
            r_mask     <= '0;
            r_window   <= '0;
            r_load_cnt <= '0;
            r_fill_cnt <= '0;
            r_out      <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_out <= w_hit;
            case (r_state)
                LOAD: begin
                    if (enable) begin
                        r_pattern  <= {r_pattern[N-2:0], prgm};
                        r_mask     <= {r_mask[N-2:0], prgm_mask};
                        r_load_cnt <= r_load_cnt + CW'(1);
                        if (w_load_last) begin
                            r_state    <= FILL;
                            r_window   <= '0;
                            r_fill_cnt <= '0;
                        end
                    end
                end
                FILL: begin
                    if (sig_valid) begin
                        if (w_fill_last && w_hit && mode_nonovl) begin
                            // Match consumed the window: collect N fresh bits.
                            r_window   <= '0;
                            r_fill_cnt <= '0;
                        end else if (w_fill_last) begin
                            r_window <= w_window_next;
                            r_state  <= ARMED;
                            r_armed  <= 1'b1;
                        end else begin
                            r_window   <= w_window_next;
                            r_fill_cnt <= r_fill_cnt + CW'(1);
                        end
                    end
                end
                ARMED: begin
                    if (sig_valid) begin
                        if (w_hit && mode_nonovl) begin
                            r_window   <= '0;
                            r_fill_cnt <= '0;
                            r_state    <= FILL;
                            r_armed    <= 1'b0;
                        end else begin
                            r_window <= w_window_next;
                        end
                    end
                end
                default: begin
                    r_state <= LOAD;
                    r_armed <= 1'b0;
                end
            endcase
        end
    end

    assign out   = r_out;
    assign armed = r_armed;

`ifdef SEQ_DEC_MATCH_CNT_EN
    logic [CNT_W-1:0] r_match_count;

    // Counts alongside out: the count changes on the same edge that raises out.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_match_count <= '0;
        end else if (w_hit && (r_match_count != {CNT_W{1'b1}})) begin
            r_match_count <= r_match_count + CNT_W'(1);
        end
    end

    assign match_count = r_match_count;
`else
    assign match_count = '0;
`endif

endmodule
